// File: rtl/centroid_divider_if.sv
// Bundle of the accumulator-side inputs and centroid-write outputs of the
// k-means centroid update stage.
interface centroid_divider_if #(
    parameter int WIDTH         = 16,
    parameter int DOUBLE_WIDTH  = 32,
    parameter int LOG_DEPTH     = 10,
    parameter int NUM_LABEL     = 8,
    parameter int LOG_NUM_LABEL = 3
);
    logic                              start;
    logic [NUM_LABEL*DOUBLE_WIDTH-1:0] xaccu_flat;
    logic [NUM_LABEL*DOUBLE_WIDTH-1:0] yaccu_flat;
    logic [NUM_LABEL*LOG_DEPTH-1:0]    count_flat;
    logic [NUM_LABEL*WIDTH-1:0]        old_x_flat;
    logic [NUM_LABEL*WIDTH-1:0]        old_y_flat;
    logic                              busy;
    logic                              cent_we;
    logic [LOG_NUM_LABEL-1:0]          cent_label;
    logic [WIDTH-1:0]                  cent_x;
    logic [WIDTH-1:0]                  cent_y;
    logic                              accu_reset;
    logic                              done;
    logic                              changed;

    modport master (
        output start, xaccu_flat, yaccu_flat, count_flat, old_x_flat, old_y_flat,
        input  busy, cent_we, cent_label, cent_x, cent_y, accu_reset, done, changed
    );

    modport slave (
        input  start, xaccu_flat, yaccu_flat, count_flat, old_x_flat, old_y_flat,
        output busy, cent_we, cent_label, cent_x, cent_y, accu_reset, done, changed
    );
endinterface

// File: rtl/centroid_divider.sv
// K-means centroid update: divides each label's x/y sums by its point count
// with two bit-serial restoring dividers and writes the new centroids.
module centroid_divider #(
    parameter int WIDTH         = 16,
    parameter int DOUBLE_WIDTH  = 32,
    parameter int LOG_DEPTH     = 10,
    parameter int NUM_LABEL     = 8,
    parameter int LOG_NUM_LABEL = 3
) (
    input logic               clk,
    input logic               rst,
    centroid_divider_if.slave bus
);
    localparam int CW = $clog2(DOUBLE_WIDTH);

    typedef enum logic [2:0] {IDLE, LOAD, DIV, WRITE, CLEAR, DONE} state_t;

    state_t                   state_q;
    logic [LOG_NUM_LABEL-1:0] label_q;
    logic [CW-1:0]            bit_q;
    logic [DOUBLE_WIDTH-1:0]  xnum_q, ynum_q, xquo_q, yquo_q;
    logic [LOG_DEPTH-1:0]     div_q, xrem_q, yrem_q;
    logic                     busy_q, cent_we_q, accu_reset_q, done_q, changed_q;
    logic [LOG_NUM_LABEL-1:0] cent_label_q;
    logic [WIDTH-1:0]         cent_x_q, cent_y_q;

    logic [DOUBLE_WIDTH-1:0]  xacc_sel, yacc_sel;
    logic [LOG_DEPTH-1:0]     cnt_sel;
    logic [WIDTH-1:0]         old_x_sel, old_y_sel;
    logic                     last_label;
    logic [LOG_DEPTH:0]       xshift, yshift, xdiff, ydiff;
    logic                     xge, yge;
    logic [LOG_DEPTH-1:0]     xrem_d, yrem_d;
    logic [DOUBLE_WIDTH-1:0]  xquo_d, yquo_d;

    function automatic logic [WIDTH-1:0] saturate(input logic [DOUBLE_WIDTH-1:0] q);
        if (|q[DOUBLE_WIDTH-1:WIDTH]) begin
            return {WIDTH{1'b1}};
        end
        return q[WIDTH-1:0];
    endfunction

    assign xacc_sel   = bus.xaccu_flat[label_q*DOUBLE_WIDTH +: DOUBLE_WIDTH];
    assign yacc_sel   = bus.yaccu_flat[label_q*DOUBLE_WIDTH +: DOUBLE_WIDTH];
    assign cnt_sel    = bus.count_flat[label_q*LOG_DEPTH +: LOG_DEPTH];
    assign old_x_sel  = bus.old_x_flat[label_q*WIDTH +: WIDTH];
    assign old_y_sel  = bus.old_y_flat[label_q*WIDTH +: WIDTH];
    assign last_label = (label_q == LOG_NUM_LABEL'(NUM_LABEL - 1));

    // One restoring step per cycle; the partial remainder always stays below the divisor.
    always_comb begin
        xshift = {xrem_q, xnum_q[DOUBLE_WIDTH-1]};
        yshift = {yrem_q, ynum_q[DOUBLE_WIDTH-1]};
        xdiff  = xshift - {1'b0, div_q};
        ydiff  = yshift - {1'b0, div_q};
        xge    = (xshift >= {1'b0, div_q});
        yge    = (yshift >= {1'b0, div_q});
        xrem_d = xge ? xdiff[LOG_DEPTH-1:0] : xshift[LOG_DEPTH-1:0];
        yrem_d = yge ? ydiff[LOG_DEPTH-1:0] : yshift[LOG_DEPTH-1:0];
        xquo_d = {xquo_q[DOUBLE_WIDTH-2:0], xge};
        yquo_d = {yquo_q[DOUBLE_WIDTH-2:0], yge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            label_q      <= '0;
            bit_q        <= '0;
            xnum_q       <= '0;
            ynum_q       <= '0;
            xquo_q       <= '0;
            yquo_q       <= '0;
            div_q        <= '0;
            xrem_q       <= '0;
            yrem_q       <= '0;
            busy_q       <= 1'b0;
            cent_we_q    <= 1'b0;
            cent_label_q <= '0;
            cent_x_q     <= '0;
            cent_y_q     <= '0;
            accu_reset_q <= 1'b0;
            done_q       <= 1'b0;
            changed_q    <= 1'b0;
        end else begin
            cent_we_q    <= 1'b0;
            accu_reset_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q   <= LOAD;
                        label_q   <= '0;
                        changed_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                LOAD: begin
                    xnum_q <= xacc_sel;
                    ynum_q <= yacc_sel;
                    div_q  <= cnt_sel;
                    xrem_q <= '0;
                    yrem_q <= '0;
                    if (cnt_sel == '0) begin
                        if (last_label) begin
                            state_q      <= CLEAR;
                            accu_reset_q <= 1'b1;
                        end else begin
                            label_q <= label_q + 1'b1;
                        end
                    end else begin
                        state_q <= DIV;
                        bit_q   <= CW'(DOUBLE_WIDTH - 1);
                    end
                end
                DIV: begin
                    xnum_q <= xnum_q << 1;
                    ynum_q <= ynum_q << 1;
                    xquo_q <= xquo_d;
                    yquo_q <= yquo_d;
                    xrem_q <= xrem_d;
                    yrem_q <= yrem_d;
                    bit_q  <= bit_q - 1'b1;
                    // The final quotient bit lands here, so the write strobe is registered now.
                    if (bit_q == '0) begin
                        state_q      <= WRITE;
                        cent_we_q    <= 1'b1;
                        cent_label_q <= label_q;
                        cent_x_q     <= saturate(xquo_d);
                        cent_y_q     <= saturate(yquo_d);
                    end
                end
                WRITE: begin
                    changed_q <= changed_q | (cent_x_q != old_x_sel) | (cent_y_q != old_y_sel);
                    if (last_label) begin
                        state_q      <= CLEAR;
                        accu_reset_q <= 1'b1;
                    end else begin
                        state_q <= LOAD;
                        label_q <= label_q + 1'b1;
                    end
                end
                CLEAR: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.cent_we    = cent_we_q;
    assign bus.cent_label = cent_label_q;
    assign bus.cent_x     = cent_x_q;
    assign bus.cent_y     = cent_y_q;
    assign bus.accu_reset = accu_reset_q;
    assign bus.done       = done_q;
    assign bus.changed    = changed_q;
endmodule

// File: tb/tb_centroid_divider.sv
// Directed and randomized passes through centroid_divider, checked against an
// arithmetic model of the per-label division and pass timing.
module tb_centroid_divider;
    localparam int W  = 16;
    localparam int DW = 32;
    localparam int LD = 10;
    localparam int NL = 8;
    localparam int LL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    centroid_divider_if #(.WIDTH(W), .DOUBLE_WIDTH(DW), .LOG_DEPTH(LD),
                          .NUM_LABEL(NL), .LOG_NUM_LABEL(LL)) bus ();

    centroid_divider #(.WIDTH(W), .DOUBLE_WIDTH(DW), .LOG_DEPTH(LD),
                       .NUM_LABEL(NL), .LOG_NUM_LABEL(LL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] xs [NL];
    logic [DW-1:0] ys [NL];
    logic [LD-1:0] cs [NL];
    logic [W-1:0]  ox [NL];
    logic [W-1:0]  oy [NL];

    int   nWrites;
    int   wrLabel [16];
    int   wrX [16];
    int   wrY [16];
    int   wrCycle [16];
    int   accuCount, accuCycle, doneCount, doneCycle;
    logic changedAtDone;
    logic busyLog [512];

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".busy"}, 64'(bus.busy), 0);
        checkOutput({tag, ".cent_we"}, 64'(bus.cent_we), 0);
        checkOutput({tag, ".cent_label"}, 64'(bus.cent_label), 0);
        checkOutput({tag, ".cent_x"}, 64'(bus.cent_x), 0);
        checkOutput({tag, ".cent_y"}, 64'(bus.cent_y), 0);
        checkOutput({tag, ".accu_reset"}, 64'(bus.accu_reset), 0);
        checkOutput({tag, ".done"}, 64'(bus.done), 0);
        checkOutput({tag, ".changed"}, 64'(bus.changed), 0);
    endtask

    task automatic packInputs();
        for (int k = 0; k < NL; k++) begin
            bus.xaccu_flat[k*DW +: DW] = xs[k];
            bus.yaccu_flat[k*DW +: DW] = ys[k];
            bus.count_flat[k*LD +: LD] = cs[k];
            bus.old_x_flat[k*W +: W]   = ox[k];
            bus.old_y_flat[k*W +: W]   = oy[k];
        end
    endtask

    // Cycle k is the k-th clock after the edge that accepted start.
    task automatic applyStimulus(input int restartA, input int restartB,
                                 input int rstAt, input int budget);
        nWrites = 0; accuCount = 0; accuCycle = -1; doneCount = 0; doneCycle = -1;
        changedAtDone = 1'bx;
        for (int i = 0; i < 512; i++) busyLog[i] = 1'b0;
        packInputs();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            if (k > 1) @(negedge clk);
            if (rstAt > 0 && k == rstAt + 1) begin
                rst = 1'b0;
                checkAllZero("midReset");
            end
            busyLog[k] = bus.busy;
            if (bus.cent_we) begin
                if (nWrites < 16) begin
                    wrLabel[nWrites] = int'(bus.cent_label);
                    wrX[nWrites]     = int'(bus.cent_x);
                    wrY[nWrites]     = int'(bus.cent_y);
                    wrCycle[nWrites] = k;
                end
                nWrites++;
            end
            if (bus.accu_reset) begin
                if (accuCount == 0) accuCycle = k;
                accuCount++;
            end
            if (bus.done) begin
                if (doneCount == 0) begin
                    doneCycle     = k;
                    changedAtDone = bus.changed;
                end
                doneCount++;
            end
            bus.start = (k == restartA || k == restartB);
            if (k == rstAt) rst = 1'b1;
            if (doneCount > 0 && k >= doneCycle + 2) break;
        end
        bus.start = 1'b0;
    endtask

    // Reference: floor division with saturation, empty labels cost one cycle,
    // non-empty ones 34, then the clear and done cycles follow.
    task automatic checkPass(input string name);
        int  expN = 0;
        int  cyc = 0;
        logic expChanged = 1'b0;
        int  eLabel [NL];
        int  eX [NL];
        int  eY [NL];
        int  eCycle [NL];
        int  busyErr = 0;
        longint unsigned qx, qy;
        for (int k = 0; k < NL; k++) begin
            if (cs[k] == 0) begin
                cyc += 1;
            end else begin
                qx = longint'(xs[k]) / longint'(cs[k]);
                qy = longint'(ys[k]) / longint'(cs[k]);
                if (qx > 65535) qx = 65535;
                if (qy > 65535) qy = 65535;
                cyc += 34;
                eLabel[expN] = k; eX[expN] = int'(qx); eY[expN] = int'(qy); eCycle[expN] = cyc;
                if (qx != longint'(ox[k]) || qy != longint'(oy[k])) expChanged = 1'b1;
                expN++;
            end
        end
        checkOutput($sformatf("%s.nWrites", name), 64'(nWrites), 64'(expN));
        for (int i = 0; i < expN && i < nWrites; i++) begin
            checkOutput($sformatf("%s.w%0d.label", name, i), 64'(wrLabel[i]), 64'(eLabel[i]));
            checkOutput($sformatf("%s.w%0d.x", name, i), 64'(wrX[i]), 64'(eX[i]));
            checkOutput($sformatf("%s.w%0d.y", name, i), 64'(wrY[i]), 64'(eY[i]));
            checkOutput($sformatf("%s.w%0d.cycle", name, i), 64'(wrCycle[i]), 64'(eCycle[i]));
        end
        checkOutput($sformatf("%s.accuCycle", name), 64'(accuCycle), 64'(cyc + 1));
        checkOutput($sformatf("%s.accuCount", name), 64'(accuCount), 1);
        checkOutput($sformatf("%s.doneCycle", name), 64'(doneCycle), 64'(cyc + 2));
        checkOutput($sformatf("%s.doneCount", name), 64'(doneCount), 1);
        checkOutput($sformatf("%s.changed", name), 64'(changedAtDone), 64'(expChanged));
        for (int k = 1; k <= cyc + 3 && k < 512; k++) begin
            if (busyLog[k] !== ((k <= cyc + 2) ? 1'b1 : 1'b0)) busyErr++;
        end
        checkOutput($sformatf("%s.busyErrors", name), 64'(busyErr), 0);
    endtask

    task automatic clearLabels();
        for (int k = 0; k < NL; k++) begin
            xs[k] = '0; ys[k] = '0; cs[k] = '0; ox[k] = '0; oy[k] = '0;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        clearLabels();
        packInputs();
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;

        // Single populated label.
        clearLabels();
        xs[3] = 1000; ys[3] = 2001; cs[3] = 10;
        applyStimulus(-1, -1, -1, 400);
        checkPass("label3");
        checkOutput("label3.x", 64'(wrX[0]), 100);
        checkOutput("label3.y", 64'(wrY[0]), 200);

        // Every label empty.
        clearLabels();
        applyStimulus(-1, -1, -1, 400);
        checkPass("allEmpty");
        checkOutput("allEmpty.accuCycle", 64'(accuCycle), 9);

        // All labels unchanged, maximal pass length.
        for (int k = 0; k < NL; k++) begin
            xs[k] = 65535; ys[k] = k; cs[k] = 1; ox[k] = 65535; oy[k] = W'(k);
        end
        applyStimulus(-1, -1, -1, 400);
        checkPass("allFull");
        checkOutput("allFull.doneCycle", 64'(doneCycle), 274);

        // Saturation and an exact quotient of one.
        clearLabels();
        xs[0] = 32'h00FF_FFFF; cs[0] = 1;
        xs[1] = 1023; cs[1] = 1023;
        applyStimulus(-1, -1, -1, 400);
        checkPass("saturate");
        checkOutput("saturate.x0", 64'(wrX[0]), 65535);

        // Reset during label 2 division, then a clean pass.
        for (int k = 0; k < NL; k++) begin
            xs[k] = 500 * (k + 1); ys[k] = 77; cs[k] = 5; ox[k] = '0; oy[k] = '0;
        end
        applyStimulus(-1, -1, 80, 300);
        checkOutput("midReset.nWrites", 64'(nWrites), 2);
        checkOutput("midReset.accuCount", 64'(accuCount), 0);
        checkOutput("midReset.doneCount", 64'(doneCount), 0);
        applyStimulus(-1, -1, -1, 400);
        checkPass("afterReset");

        // Start re-pulsed during a pass.
        applyStimulus(5, 100, -1, 400);
        checkPass("restart");

        // Randomized passes.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NL; k++) begin
                cs[k] = ($urandom_range(0, 3) == 0) ? '0 : LD'($urandom_range(1, 1023));
                xs[k] = $urandom >> $urandom_range(0, 24);
                ys[k] = $urandom >> $urandom_range(0, 24);
                ox[k] = W'($urandom);
                oy[k] = W'($urandom);
                if ($urandom_range(0, 1) == 0 && cs[k] != 0) begin
                    ox[k] = (xs[k] / cs[k] > 65535) ? 16'hFFFF : W'(xs[k] / cs[k]);
                    oy[k] = (ys[k] / cs[k] > 65535) ? 16'hFFFF : W'(ys[k] / cs[k]);
                end
            end
            applyStimulus(-1, -1, -1, 400);
            checkPass($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
